// File: rtl/hart_mem_arbiter_pkg.sv
// Shared definitions for the hart memory arbiter: FSM encodings, grant IDs
// and the funct3 code used for instruction fetches.
package hart_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS_I = 2'd1,
      ST_BUS_D = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam logic ARB_GRANT_I = 1'b0;
   localparam logic ARB_GRANT_D = 1'b1;

   localparam logic [2:0] FETCH_F3 = 3'b010;

endpackage

// File: rtl/hart_arb_timeout.sv
// Loadable down-counter that flags expiry while enabled and at zero.
module hart_arb_timeout #(
   parameter int TO_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [TO_W-1:0] load_val,
   input  logic            en,
   output logic            expired
);

   logic [TO_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - TO_W'(1);
      end
   end

   assign expired = en & (count_reg == '0);

endmodule

// File: rtl/hart_mem_arbiter.sv
// Round-robin arbiter sharing one memory bus port between the hart's fetch
// and data channels; one outstanding transaction, registered responses.
module hart_mem_arbiter
   import hart_mem_arbiter_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 0,
   parameter int TO_W    = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_IC_DataReq,
   input  logic [XLEN-1:0] i_IM_Addr,
   output logic            o_IC_MemReady,
   output logic [XLEN-1:0] o_IM_Instr,
   input  logic            i_DM_MemRead,
   input  logic            i_DM_Wen,
   input  logic [XLEN-1:0] i_DM_Addr,
   input  logic [XLEN-1:0] i_DM_WriteData,
   input  logic [2:0]      i_DM_f3,
   output logic            o_DM_Ready,
   output logic [XLEN-1:0] o_DM_ReadData,
   output logic            o_Err,
   output logic            o_BUS_Req,
   output logic [XLEN-1:0] o_BUS_Addr,
   output logic            o_BUS_Wen,
   output logic [XLEN-1:0] o_BUS_WriteData,
   output logic [2:0]      o_BUS_f3,
   input  logic            i_BUS_Ready,
   input  logic [XLEN-1:0] i_BUS_ReadData
);

   arb_state_t      state_reg, state_next;
   logic            last_grant_reg;
   logic [XLEN-1:0] bus_addr_reg, bus_wdata_reg, im_instr_reg, dm_rdata_reg;
   logic [2:0]      bus_f3_reg;
   logic            bus_wen_reg, err_reg;

   logic dr, ir, grant_d, grant_en, bus_active, to_expired;

   assign dr         = i_DM_MemRead | i_DM_Wen;
   assign ir         = i_IC_DataReq;
   // On a tie the data channel wins only if fetch was served last.
   assign grant_d    = dr & (~ir | (last_grant_reg == ARB_GRANT_I));
   assign grant_en   = (state_reg == ST_IDLE) & (ir | dr);
   assign bus_active = (state_reg == ST_BUS_I) | (state_reg == ST_BUS_D);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (ir | dr) state_next = grant_d ? ST_BUS_D : ST_BUS_I;
         ST_BUS_I,
         ST_BUS_D: if (i_BUS_Ready | to_expired) state_next = ST_RESP;
         ST_RESP:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_grant_reg <= ARB_GRANT_D;
         bus_addr_reg   <= '0;
         bus_wdata_reg  <= '0;
         bus_f3_reg     <= '0;
         bus_wen_reg    <= 1'b0;
         err_reg        <= 1'b0;
         im_instr_reg   <= '0;
         dm_rdata_reg   <= '0;
      end else begin
         if (grant_en) begin
            last_grant_reg <= grant_d ? ARB_GRANT_D : ARB_GRANT_I;
            bus_addr_reg   <= grant_d ? i_DM_Addr : i_IM_Addr;
            bus_wdata_reg  <= grant_d ? i_DM_WriteData : '0;
            bus_f3_reg     <= grant_d ? i_DM_f3 : FETCH_F3;
            bus_wen_reg    <= grant_d & i_DM_Wen;
         end
         if (bus_active) begin
            // Completion on the expiry cycle counts as a normal response.
            err_reg <= to_expired & ~i_BUS_Ready;
            if (i_BUS_Ready) begin
               if (state_reg == ST_BUS_I) begin
                  im_instr_reg <= i_BUS_ReadData;
               end else if (!bus_wen_reg) begin
                  dm_rdata_reg <= i_BUS_ReadData;
               end
            end
         end
      end
   end

   generate
      if (TIMEOUT != 0) begin : g_timeout
         localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
         hart_arb_timeout #(
            .TO_W(TO_W)
         ) u_timeout (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .load     (grant_en),
            .load_val (TO_LOAD),
            .en       (bus_active),
            .expired  (to_expired)
         );
      end else begin : g_no_timeout
         assign to_expired = 1'b0;
      end
   endgenerate

   assign o_BUS_Req       = bus_active;
   assign o_BUS_Addr      = bus_addr_reg;
   assign o_BUS_Wen       = bus_wen_reg;
   assign o_BUS_WriteData = bus_wdata_reg;
   assign o_BUS_f3        = bus_f3_reg;
   assign o_IC_MemReady   = (state_reg == ST_RESP) & (last_grant_reg == ARB_GRANT_I);
   assign o_DM_Ready      = (state_reg == ST_RESP) & (last_grant_reg == ARB_GRANT_D);
   assign o_Err           = (state_reg == ST_RESP) & err_reg;
   assign o_IM_Instr      = im_instr_reg;
   assign o_DM_ReadData   = dm_rdata_reg;

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Bench for hart_mem_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_hart_mem_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_IC_DataReq;
   logic [31:0] i_IM_Addr;
   logic        o_IC_MemReady;
   logic [31:0] o_IM_Instr;
   logic        i_DM_MemRead;
   logic        i_DM_Wen;
   logic [31:0] i_DM_Addr;
   logic [31:0] i_DM_WriteData;
   logic [2:0]  i_DM_f3;
   logic        o_DM_Ready;
   logic [31:0] o_DM_ReadData;
   logic        o_Err;
   logic        o_BUS_Req;
   logic [31:0] o_BUS_Addr;
   logic        o_BUS_Wen;
   logic [31:0] o_BUS_WriteData;
   logic [2:0]  o_BUS_f3;
   logic        i_BUS_Ready;
   logic [31:0] i_BUS_ReadData;

   int n_checks = 0;
   int n_err    = 0;

   hart_mem_arbiter #(
      .XLEN    (32),
      .TIMEOUT (TB_TIMEOUT),
      .TO_W    (8)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_IC_DataReq    (i_IC_DataReq),
      .i_IM_Addr       (i_IM_Addr),
      .o_IC_MemReady   (o_IC_MemReady),
      .o_IM_Instr      (o_IM_Instr),
      .i_DM_MemRead    (i_DM_MemRead),
      .i_DM_Wen        (i_DM_Wen),
      .i_DM_Addr       (i_DM_Addr),
      .i_DM_WriteData  (i_DM_WriteData),
      .i_DM_f3         (i_DM_f3),
      .o_DM_Ready      (o_DM_Ready),
      .o_DM_ReadData   (o_DM_ReadData),
      .o_Err           (o_Err),
      .o_BUS_Req       (o_BUS_Req),
      .o_BUS_Addr      (o_BUS_Addr),
      .o_BUS_Wen       (o_BUS_Wen),
      .o_BUS_WriteData (o_BUS_WriteData),
      .o_BUS_f3        (o_BUS_f3),
      .i_BUS_Ready     (i_BUS_Ready),
      .i_BUS_ReadData  (i_BUS_ReadData)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight; it is either on the bus
   // (counting its bus cycles), in its response cycle, or nothing is in flight.
   logic        m_on_bus, m_resp, m_chan_d, m_last_d, m_err, m_wen;
   int          m_age;
   logic [31:0] m_addr, m_wdata, m_instr, m_rdata;
   logic [2:0]  m_f3;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_on_bus <= 1'b0; m_resp <= 1'b0; m_chan_d <= 1'b0; m_last_d <= 1'b1;
         m_err <= 1'b0; m_wen <= 1'b0; m_age <= 0; m_addr <= '0; m_wdata <= '0;
         m_instr <= '0; m_rdata <= '0; m_f3 <= '0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (m_on_bus) begin
         m_age <= m_age + 1;
         if (i_BUS_Ready) begin
            if (!m_chan_d) m_instr <= i_BUS_ReadData;
            else if (!m_wen) m_rdata <= i_BUS_ReadData;
            m_err <= 1'b0; m_on_bus <= 1'b0; m_resp <= 1'b1;
         end else if (m_age + 1 == TB_TIMEOUT) begin
            m_err <= 1'b1; m_on_bus <= 1'b0; m_resp <= 1'b1;
         end
      end else if (i_IC_DataReq || i_DM_MemRead || i_DM_Wen) begin
         m_on_bus <= 1'b1;
         m_age    <= 0;
         if ((i_DM_MemRead || i_DM_Wen) && (!i_IC_DataReq || !m_last_d)) begin
            m_chan_d <= 1'b1; m_last_d <= 1'b1;
            m_addr <= i_DM_Addr; m_wdata <= i_DM_WriteData; m_f3 <= i_DM_f3;
            m_wen <= i_DM_Wen;
         end else begin
            m_chan_d <= 1'b0; m_last_d <= 1'b0;
            m_addr <= i_IM_Addr; m_wdata <= '0; m_f3 <= 3'b010; m_wen <= 1'b0;
         end
      end
   end

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         chk("m_req",    32'(o_BUS_Req),     32'(m_on_bus));
         chk("m_addr",   o_BUS_Addr,         m_addr);
         chk("m_wen",    32'(o_BUS_Wen),     32'(m_wen));
         chk("m_wdata",  o_BUS_WriteData,    m_wdata);
         chk("m_f3",     32'(o_BUS_f3),      32'(m_f3));
         chk("m_ic_rdy", 32'(o_IC_MemReady), 32'(m_resp && !m_chan_d));
         chk("m_dm_rdy", 32'(o_DM_Ready),    32'(m_resp && m_chan_d));
         chk("m_err",    32'(o_Err),         32'(m_resp && m_err));
         chk("m_instr",  o_IM_Instr,         m_instr);
         chk("m_rdata",  o_DM_ReadData,      m_rdata);
         chk("m_onehot", 32'(o_IC_MemReady && o_DM_Ready), 32'(0));
      end
   end

   task automatic wait_req(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_BUS_Req && n < 20);
      chk(tag, 32'(o_BUS_Req), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   int  n_req;
   bit  seen;

   initial begin
      i_rst_n = 1'b0; i_IC_DataReq = 0; i_IM_Addr = 0; i_DM_MemRead = 0; i_DM_Wen = 0;
      i_DM_Addr = 0; i_DM_WriteData = 0; i_DM_f3 = 0; i_BUS_Ready = 0; i_BUS_ReadData = 0;
      repeat (3) @(negedge i_clk);
      chk("rst_req",   32'(o_BUS_Req), 32'(0));
      chk("rst_ready", 32'({o_IC_MemReady, o_DM_Ready, o_Err}), 32'(0));
      chk("rst_instr", o_IM_Instr, 32'h0);
      chk("rst_rdata", o_DM_ReadData, 32'h0);
      chk("rst_bus",   o_BUS_Addr | o_BUS_WriteData | 32'(o_BUS_f3) | 32'(o_BUS_Wen), 32'h0);
      i_rst_n = 1'b1;

      // Lone fetch
      @(negedge i_clk); i_IC_DataReq = 1; i_IM_Addr = 32'h100;
      @(negedge i_clk);
      chk("fetch_req_c1", 32'(o_BUS_Req), 32'(1));
      chk("fetch_addr",   o_BUS_Addr, 32'h100);
      chk("fetch_f3",     32'(o_BUS_f3), 32'(3'b010));
      @(negedge i_clk);
      @(negedge i_clk);
      chk("fetch_req_c3", 32'(o_BUS_Req), 32'(1));
      i_BUS_Ready = 1; i_BUS_ReadData = 32'h13;
      @(negedge i_clk);
      i_BUS_Ready = 0; i_BUS_ReadData = 0; i_IC_DataReq = 0;
      chk("fetch_rdy",   32'(o_IC_MemReady), 32'(1));
      chk("fetch_instr", o_IM_Instr, 32'h13);
      chk("fetch_req_c4", 32'(o_BUS_Req), 32'(0));

      // Store
      @(negedge i_clk);
      i_DM_Wen = 1; i_DM_Addr = 32'h2000; i_DM_WriteData = 32'hDEADBEEF; i_DM_f3 = 3'b010;
      @(negedge i_clk);
      chk("st_wen",   32'(o_BUS_Wen), 32'(1));
      chk("st_addr",  o_BUS_Addr, 32'h2000);
      chk("st_wdata", o_BUS_WriteData, 32'hDEADBEEF);
      i_BUS_Ready = 1; i_BUS_ReadData = 32'hCAFE0001;
      @(negedge i_clk);
      i_BUS_Ready = 0; i_DM_Wen = 0;
      chk("st_rdy",   32'(o_DM_Ready), 32'(1));
      chk("st_rdata", o_DM_ReadData, 32'h0);

      // Bus ready while idle is ignored
      @(negedge i_clk); i_BUS_Ready = 1; i_BUS_ReadData = 32'hBAD;
      @(negedge i_clk); i_BUS_Ready = 0;
      @(negedge i_clk);
      chk("idle_rdy_rdata", o_DM_ReadData, 32'h0);
      chk("idle_rdy_instr", o_IM_Instr, 32'h13);

      // Read and write together behave as a write
      i_DM_MemRead = 1; i_DM_Wen = 1; i_DM_Addr = 32'h2100; i_DM_WriteData = 32'h12345678;
      i_DM_f3 = 3'b001;
      wait_req("rw_req");
      chk("rw_wen", 32'(o_BUS_Wen), 32'(1));
      i_BUS_Ready = 1; i_BUS_ReadData = 32'h99;
      @(negedge i_clk);
      i_BUS_Ready = 0; i_DM_MemRead = 0; i_DM_Wen = 0;
      chk("rw_rdy",   32'(o_DM_Ready), 32'(1));
      chk("rw_rdata", o_DM_ReadData, 32'h0);

      // Tie after reset alternates I, D, I, D
      @(negedge i_clk); i_rst_n = 0;
      @(negedge i_clk); i_rst_n = 1;
      i_IC_DataReq = 1; i_DM_MemRead = 1; i_IM_Addr = 32'h400; i_DM_Addr = 32'h3000;
      i_DM_f3 = 3'b100;
      for (int t = 0; t < 4; t++) begin
         wait_req("tie_req");
         chk("tie_addr", o_BUS_Addr, (t % 2 == 0) ? 32'h400 : 32'h3000);
         i_BUS_Ready = 1; i_BUS_ReadData = 32'h1000 + 32'(t);
         @(negedge i_clk);
         i_BUS_Ready = 0;
         chk("tie_ic_rdy", 32'(o_IC_MemReady), 32'(t % 2 == 0));
         chk("tie_dm_rdy", 32'(o_DM_Ready),    32'(t % 2 == 1));
      end
      i_IC_DataReq = 0; i_DM_MemRead = 0;

      // Timeout on a fetch
      @(negedge i_clk); i_IC_DataReq = 1; i_IM_Addr = 32'h500;
      n_req = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge i_clk);
         if (o_BUS_Req) n_req++;
         if (o_IC_MemReady) begin
            seen = 1;
            chk("to_err",   32'(o_Err), 32'(1));
            chk("to_instr", o_IM_Instr, 32'h1002);
            i_IC_DataReq = 0;
         end
      end
      chk("to_seen",       32'(seen), 32'(1));
      chk("to_req_cycles", 32'(n_req), 32'(4));

      // Reset in the middle of a data transaction
      @(negedge i_clk); i_DM_MemRead = 1; i_DM_Addr = 32'h6000;
      wait_req("mr_req");
      #2 i_rst_n = 0;
      #1 chk("mr_req_drop", 32'(o_BUS_Req), 32'(0));
      @(negedge i_clk); i_DM_MemRead = 0; i_rst_n = 1;
      repeat (2) begin
         @(negedge i_clk);
         chk("mr_no_rdy", 32'(o_DM_Ready), 32'(0));
      end
      i_IC_DataReq = 1; i_DM_MemRead = 1; i_IM_Addr = 32'h440; i_DM_Addr = 32'h6400;
      wait_req("mr_tie_req");
      chk("mr_tie_addr", o_BUS_Addr, 32'h440);
      i_BUS_Ready = 1; i_BUS_ReadData = 32'h77;
      @(negedge i_clk);
      i_BUS_Ready = 0; i_IC_DataReq = 0; i_DM_MemRead = 0;
      chk("mr_tie_rdy",   32'(o_IC_MemReady), 32'(1));
      chk("mr_tie_instr", o_IM_Instr, 32'h77);

      // Requester drops mid-transaction, ready arrives later
      @(negedge i_clk); i_DM_MemRead = 1; i_DM_Addr = 32'h7000;
      wait_req("drop_req");
      i_DM_MemRead = 0;
      @(negedge i_clk);
      @(negedge i_clk); i_BUS_Ready = 1; i_BUS_ReadData = 32'h55;
      @(negedge i_clk); i_BUS_Ready = 0;
      chk("drop_rdy",   32'(o_DM_Ready), 32'(1));
      chk("drop_rdata", o_DM_ReadData, 32'h55);
      @(negedge i_clk);
      chk("drop_idle_req", 32'(o_BUS_Req), 32'(0));
      chk("drop_idle_rdy", 32'(o_DM_Ready | o_IC_MemReady), 32'(0));

      repeat (3) @(negedge i_clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
